// File: rtl/board_pkg.sv
// Shared board definitions for the five-in-a-row blocks: cell encoding,
// board geometry, address field helpers and the board store FSM states.
package board_pkg;

  localparam int unsigned BOARD_ROW_BITS  = 4;
  localparam int unsigned BOARD_COL_BITS  = 4;
  localparam int unsigned BOARD_ROWS      = 1 << BOARD_ROW_BITS;
  localparam int unsigned BOARD_COLS      = 1 << BOARD_COL_BITS;
  localparam int unsigned BOARD_ADDR_BITS = BOARD_ROW_BITS + BOARD_COL_BITS;
  localparam int unsigned BOARD_CELLS     = BOARD_ROWS * BOARD_COLS;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef logic [BOARD_ADDR_BITS-1:0] board_addr_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } board_state_e;

  // Address is {row, col} with the row in the upper bits.
  function automatic logic [BOARD_ROW_BITS-1:0] addr_row(input board_addr_t a);
    return a[BOARD_ADDR_BITS-1:BOARD_COL_BITS];
  endfunction

  function automatic logic [BOARD_COL_BITS-1:0] addr_col(input board_addr_t a);
    return a[BOARD_COL_BITS-1:0];
  endfunction

  function automatic board_addr_t cell_addr(input logic [BOARD_ROW_BITS-1:0] row,
                                            input logic [BOARD_COL_BITS-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/board_ram.sv
// Board cell storage: one synchronous read port and one write port.
// A read and write to the same cell on one edge returns the old contents.
import board_pkg::*;

module board_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [1:0] mem [0:DEPTH-1];

  // Array has no reset; the owner sweeps it clean after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= CELL_EMPTY;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/board_store.sv
// Board memory responder: clears the grid after reset or on request, serves
// checker reads, and accepts placements only onto empty cells.
import board_pkg::*;

module board_store #(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned COL_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ROW_BITS+COL_BITS-1:0] rd_addr,
  output logic [1:0]                 rd_data,
  input  logic                       wr_req,
  input  logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  input  logic [1:0]                 wr_chess,
  output logic                       wr_ack,
  output logic                       wr_reject,
  input  logic                       clear_req,
  output logic                       busy,
  output logic [ROW_BITS+COL_BITS:0] piece_count,
  output logic                       full
);

  localparam int unsigned ADDR_W  = ROW_BITS + COL_BITS;
  localparam int unsigned CELLS   = 1 << ADDR_W;
  localparam int unsigned COUNT_W = ADDR_W + 1;

  board_state_e      state;
  logic [ADDR_W-1:0] sweep;
  logic [CELLS-1:0]  occupied;

  // Placement captured on one edge and resolved on the next.
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [1:0]        pend_chess;

  logic              pend_ok_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_waddr_c;
  logic [1:0]        ram_wdata_c;

  assign pend_ok_c = pend_valid && !occupied[pend_addr] &&
                     (pend_chess == CELL_BLACK || pend_chess == CELL_WHITE);

  // Write port: sweep owns it while clearing, otherwise accepted placements.
  always_comb begin
    ram_we_c    = 1'b0;
    ram_waddr_c = pend_addr;
    ram_wdata_c = pend_chess;
    if (state == ST_CLEAR) begin
      ram_we_c    = 1'b1;
      ram_waddr_c = sweep;
      ram_wdata_c = CELL_EMPTY;
    end else if (pend_ok_c) begin
      ram_we_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_CLEAR;
      sweep       <= '0;
      busy        <= 1'b1;
      occupied    <= '0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      pend_chess  <= CELL_EMPTY;
      wr_ack      <= 1'b0;
      wr_reject   <= 1'b0;
      piece_count <= '0;
      full        <= 1'b0;
    end else begin
      wr_ack     <= pend_ok_c;
      wr_reject  <= pend_valid && !pend_ok_c;
      pend_valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          sweep <= sweep + 1'b1;
          if (sweep == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (pend_ok_c) begin
            occupied[pend_addr] <= 1'b1;
            piece_count         <= piece_count + 1'b1;
            full                <= (piece_count == COUNT_W'(CELLS - 1));
          end
          // A placement already in flight still completes; the sweep wipes it.
          if (clear_req) begin
            state       <= ST_CLEAR;
            sweep       <= '0;
            busy        <= 1'b1;
            occupied    <= '0;
            piece_count <= '0;
            full        <= 1'b0;
          end else if (wr_req) begin
            pend_valid <= 1'b1;
            pend_addr  <= wr_addr;
            pend_chess <= wr_chess;
          end
        end
      endcase
    end
  end

  board_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .we      (ram_we_c),
    .wr_addr (ram_waddr_c),
    .wr_data (ram_wdata_c)
  );

endmodule

// File: tb/tb_board_store.sv
// Bench for board_store: board-level model checked every cycle, plus
// directed placements, clears, a full fill and a mid-clear reset.
module tb_board_store;
  import board_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rd_addr;
  logic [1:0] rd_data;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [1:0] wr_chess;
  logic       wr_ack;
  logic       wr_reject;
  logic       clear_req;
  logic       busy;
  logic [8:0] piece_count;
  logic       full;

  int n_vec = 0;
  int n_err = 0;

  board_store dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_chess    (wr_chess),
    .wr_ack      (wr_ack),
    .wr_reject   (wr_reject),
    .clear_req   (clear_req),
    .busy        (busy),
    .piece_count (piece_count),
    .full        (full)
  );

  always #5 clk = ~clk;

  // Board model: cell contents, clear countdown, one pending placement.
  logic [1:0] m_cells [0:255];
  int         m_left;
  int         m_count;
  bit         m_pend;
  logic [7:0] m_paddr;
  logic [1:0] m_pchess;
  bit         m_idle;
  bit         m_ok;
  bit         exp_ack, exp_rej, rd_valid;
  logic [1:0] exp_rd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) m_cells[i] = 2'b00;
      m_left = 256; m_count = 0; m_pend = 0;
      exp_ack = 0; exp_rej = 0; exp_rd = 2'b00; rd_valid = 1;
    end else begin
      m_idle   = (m_left == 0);
      rd_valid = m_idle;
      exp_rd   = m_cells[rd_addr];
      exp_ack  = 0;
      exp_rej  = 0;
      if (m_pend) begin
        m_ok = (m_cells[m_paddr] == 2'b00) && (m_pchess == 2'b01 || m_pchess == 2'b10);
        exp_ack = m_ok;
        exp_rej = !m_ok;
        if (m_ok) begin
          m_cells[m_paddr] = m_pchess;
          m_count++;
        end
        m_pend = 0;
      end
      if (!m_idle) begin
        m_left--;
      end else if (clear_req) begin
        m_left = 256; m_count = 0;
        for (int i = 0; i < 256; i++) m_cells[i] = 2'b00;
      end else if (wr_req) begin
        m_pend = 1; m_paddr = wr_addr; m_pchess = wr_chess;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("wr_ack", int'(wr_ack), int'(exp_ack));
    cmp("wr_reject", int'(wr_reject), int'(exp_rej));
    cmp("busy", int'(busy), int'(m_left != 0));
    cmp("piece_count", int'(piece_count), m_count);
    cmp("full", int'(full), int'(m_count == 256));
    if (rd_valid) cmp("rd_data", int'(rd_data), int'(exp_rd));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write1(input logic [7:0] a, input logic [1:0] c,
                        output logic ack, output logic rej);
    wr_req = 1'b1; wr_addr = a; wr_chess = c;
    tick();
    wr_req = 1'b0;
    tick();
    ack = wr_ack; rej = wr_reject;
  endtask

  task automatic read1(input logic [7:0] a, output logic [1:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 400) begin
      tick();
      cycles++;
    end
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, cycles);
    end
  endtask

  logic       ack, rej;
  logic [1:0] d;
  int         cyc;

  initial begin
    reset = 1'b1; rd_addr = 8'h00; wr_req = 1'b0; wr_addr = 8'h00;
    wr_chess = 2'b00; clear_req = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;

    // Power-up sweep length and empty board
    wait_idle(cyc);
    cmp("lit_sweep_cycles", cyc, 256);
    cmp("lit_count_after_reset", int'(piece_count), 0);
    read1(8'h37, d); cmp("lit_rd_37_empty", int'(d), 0);
    read1(8'hFF, d); cmp("lit_rd_ff_empty", int'(d), 0);

    // Place black at 0x37, then refuse white on top of it
    write1(8'h37, CELL_BLACK, ack, rej);
    cmp("lit_ack_37", int'(ack), 1); cmp("lit_rej_37", int'(rej), 0);
    read1(8'h37, d); cmp("lit_rd_37_black", int'(d), 1);
    cmp("lit_count_1", int'(piece_count), 1);
    write1(8'h37, CELL_WHITE, ack, rej);
    cmp("lit_rej_37_occupied", int'(rej), 1); cmp("lit_noack_37", int'(ack), 0);
    read1(8'h37, d); cmp("lit_rd_37_still_black", int'(d), 1);
    cmp("lit_count_still_1", int'(piece_count), 1);

    // Illegal piece codes
    write1(8'h00, 2'b11, ack, rej);
    cmp("lit_rej_code11", int'(rej), 1);
    write1(8'h00, 2'b00, ack, rej);
    cmp("lit_rej_code00", int'(rej), 1);
    read1(8'h00, d); cmp("lit_rd_00_empty", int'(d), 0);

    // Back-to-back requests to one cell: second sees the first
    wr_req = 1'b1; wr_addr = 8'h50; wr_chess = CELL_WHITE; rd_addr = 8'h50;
    tick(); tick();
    wr_req = 1'b0;
    cmp("lit_b2b_first_ack", int'(wr_ack), 1);
    tick();
    cmp("lit_b2b_second_rej", int'(wr_reject), 1);
    cmp("lit_count_2", int'(piece_count), 2);

    // Clear with a simultaneous write, plus a write ignored mid-clear
    wr_req = 1'b1; wr_addr = 8'h12; wr_chess = CELL_BLACK; clear_req = 1'b1;
    tick();
    wr_req = 1'b0; clear_req = 1'b0;
    tick();
    cmp("lit_clear_noack", int'(wr_ack), 0); cmp("lit_clear_norej", int'(wr_reject), 0);
    cmp("lit_clear_busy", int'(busy), 1);
    tick(); tick(); tick();
    wr_req = 1'b1; wr_addr = 8'h44; wr_chess = CELL_WHITE;
    tick();
    wr_req = 1'b0;
    wait_idle(cyc);
    read1(8'h37, d); cmp("lit_rd_37_cleared", int'(d), 0);
    read1(8'h12, d); cmp("lit_rd_12_cleared", int'(d), 0);
    read1(8'h44, d); cmp("lit_rd_44_cleared", int'(d), 0);
    cmp("lit_count_cleared", int'(piece_count), 0);

    // Fill the board with alternating colours, streaming one per cycle
    for (int i = 0; i < 256; i++) begin
      wr_req = 1'b1; wr_addr = 8'(i);
      wr_chess = (i % 2 == 1) ? CELL_WHITE : CELL_BLACK;
      rd_addr = 8'(255 - i);
      tick();
    end
    wr_req = 1'b0;
    tick();
    cmp("lit_last_ack", int'(wr_ack), 1);
    cmp("lit_full", int'(full), 1);
    cmp("lit_count_256", int'(piece_count), 256);
    read1(8'h01, d); cmp("lit_rd_01_white", int'(d), 2);
    write1(8'h99, CELL_BLACK, ack, rej);
    cmp("lit_rej_when_full", int'(rej), 1);

    // Clear, a few writes, clear again and reset partway through the sweep
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    wait_idle(cyc);
    write1(8'h21, CELL_BLACK, ack, rej);
    write1(8'h22, CELL_WHITE, ack, rej);
    cmp("lit_count_before_reset", int'(piece_count), 2);
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    #1;
    cmp("lit_rst_busy", int'(busy), 1); cmp("lit_rst_count", int'(piece_count), 0);
    cmp("lit_rst_ack", int'(wr_ack), 0); cmp("lit_rst_rd", int'(rd_data), 0);
    tick(); tick();
    reset = 1'b0;
    wait_idle(cyc);
    cmp("lit_resweep_cycles", cyc, 256);
    read1(8'h21, d); cmp("lit_rd_21_after_reset", int'(d), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
